// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the TDM demux path
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  function automatic slot_t next_slot(input slot_t s);
    return (s == LAST_SLOT) ? slot_t'(0) : slot_t'(s + slot_t'(1));
  endfunction

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// rtl/tdm_demux_4ch_if.sv - sample stream in, frame-aligned lane bus out
interface tdm_demux_4ch_if #(
  parameter int W = 8
);
  import tdm_pkg::*;

  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] y;
  logic           frame_valid;
  logic           locked;
  slot_t          slot;
  logic           sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y, frame_valid, locked, slot, sync_err
  );
endinterface

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - frame-aligning 4-slot TDM demultiplexer with flywheel lock
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int W        = 8,
  parameter int FLYWHEEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_4ch_if.slave    bus
);

  state_e              state_q, state_d;
  slot_t               slot_q, slot_d;
  logic [2:0]          miss_q, miss_d;
  logic [2:0][W-1:0]   shadow_q, shadow_d;
  logic [4*W-1:0]      y_q, y_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      miss_q   <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_d[0] = bus.din;
            slot_d      = slot_t'(1);
            miss_d      = '0;
            state_d     = LOCK;
          end
        end

        LOCK: begin
          if (slot_q == slot_t'(0)) begin
            if (bus.frame_sync) begin
              shadow_d[0] = bus.din;
              slot_d      = slot_t'(1);
              miss_d      = '0;
            end else if (miss_q < 3'(FLYWHEEL)) begin
              // Marker missing but still inside the flywheel window: trust the count.
              shadow_d[0] = bus.din;
              slot_d      = slot_t'(1);
              miss_d      = miss_q + 3'd1;
              err_d       = 1'b1;
            end else begin
              err_d   = 1'b1;
              slot_d  = '0;
              miss_d  = '0;
              state_d = HUNT;
            end
          end else if (bus.frame_sync) begin
            // Early marker: abandon the partial frame and restart on this sample.
            err_d       = 1'b1;
            shadow_d[0] = bus.din;
            slot_d      = slot_t'(1);
            miss_d      = '0;
          end else begin
            unique case (slot_q)
              2'd1:    shadow_d[1] = bus.din;
              2'd2:    shadow_d[2] = bus.din;
              default: begin
                y_d  = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                fv_d = 1'b1;
              end
            endcase
            slot_d = next_slot(slot_q);
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = (state_q == LOCK);
  assign bus.slot        = slot_q;

endmodule
